pheap_level_link: RTL and testbench
===================================

// Module: pheap_level_link
// PURPOSE
//  Parametrised inter-level link for the pipelined heap (pheap). It carries an operation token
//  (op, key, node position) from level LEVEL to level LEVEL+1.
//  - Buffers the token in a DEPTH-entry skid FIFO with a valid/ready handshake.
//  - Extends the position by the child-direction bit chosen at this level.
//  - Gives upstream levels a position-hazard lookup.
//  Sits between the level-LEVEL node logic and the level-LEVEL+1 node logic.
// PARAMETERS
//  LEVEL  2   heap level driving this link (>=2); in_pos is LEVEL-1 bits, out_pos is LEVEL bits
//  KW     16  key width in bits (>=1)
//  DEPTH  2   FIFO entries; power of two, >=2
// PORTS
//  clk        in   1              clock, all state on rising edge
//  rst        in   1              synchronous, active-high reset
//  flush      in   1              synchronous drop of all buffered tokens
//  in_valid   in   1              upstream token valid
//  in_ready   out  1              link can accept a token this cycle
//  in_op      in   2              00 NOP, 01 INSERT, 10 REMOVE, 11 reserved
//  in_key     in   KW             key carried with token
//  in_pos     in   LEVEL-1        node position at level LEVEL
//  in_dir     in   1              child select: 0 left, 1 right
//  out_valid  out  1              head token valid
//  out_ready  in   1              downstream accepts head token
//  out_op     out  2              head op
//  out_key    out  KW             head key
//  out_pos    out  LEVEL          head position at LEVEL+1 = {pos_in, dir}
//  count      out  $clog2(DEPTH+1)  occupied entries
//  chk_pos    in   LEVEL          position queried by upstream hazard logic
//  chk_hit    out  1              chk_pos matches any occupied entry's out_pos
//  err        out  1              sticky: reserved op (11) was accepted
// BEHAVIOUR
//  - Reset: rst is synchronous, active-high; clk is the clock. Reset has the highest priority.
//    Reset clears count, pointers, err and all storage, so out_valid=0, out_op=0, out_key=0,
//    out_pos=0 and chk_hit=0 on the cycle after rst.
//  - Handshake:
//    - in_ready = (count < DEPTH) & ~flush. It never depends on out_ready, so there is no
//      pass-through when full.
//    - Push happens when in_valid & in_ready; pop happens when out_valid & out_ready.
//    - out_valid = (count != 0). Head fields come from storage and are stable while
//      out_valid & ~out_ready.
//  - Stored entry on push: {in_op, in_key, {in_pos, in_dir}}.
//    - NOP (00): accepted (handshake completes) but not stored; count unchanged.
//    - Reserved op (11): accepted, not stored, sets err=1 until rst.
//  - Latency: a token pushed at edge N is visible on out_* after edge N. It can pop at edge N+1
//    at the earliest. Throughput is 1 token/cycle when not full.
//  - Simultaneous push and pop (count in 1..DEPTH-1): count unchanged; the head advances to the
//    next entry.
//    - count==0: push only; no same-cycle bypass.
//    - count==DEPTH: pop only, since in_ready=0.
//  - Pointers are log2(DEPTH) bits and wrap modulo DEPTH with no special case.
//  - count saturates structurally: never >DEPTH, never <0.
//  - flush (rst=0): next cycle count=0 and out_valid=0; a same-cycle push or pop is discarded.
//    flush does not clear err or storage contents.
//  - chk_hit: combinational OR over occupied entries of (entry.pos == chk_pos).
//    - Entries are indexed rd_ptr..rd_ptr+count-1 with wrap.
//    - Stale storage outside that range never matches.
//  - Reset mid-transfer: any in-flight token is dropped and no partial entry survives.
// TESTING
//  - Reset/idle: hold rst 3 cycles with in_valid=1 -> count=0, out_valid=0, out_pos=0, err=0,
//    chk_hit=0.
//  - Single token (LEVEL=3): push INSERT key=0x00A5 pos=2'b10 dir=1 with out_ready=0 ->
//    next cycle out_valid=1, out_pos=3'b101, count=1.
//    Then chk_pos=3'b101 -> chk_hit=1; chk_pos=3'b100 -> chk_hit=0.
//  - Fill/backpressure (DEPTH=2): push 3 back-to-back with out_ready=0 -> in_ready=0 after 2;
//    the third stays pending. Raise out_ready -> pops in order 1,2,3 with no loss or duplication.
//  - Steady stream: 20 tokens, in_valid=out_ready=1 -> one token/cycle, count stays 1, order kept
//    across at least 5 pointer wraps.
//  - NOP/reserved: push op=00 then op=11 -> both handshake, count stays 0, err=1 from the cycle
//    after the 11 push until rst.
//  - Flush collision: count=2 with flush, push and pop in the same cycle -> next cycle count=0,
//    out_valid=0, chk_hit=0 for all chk_pos; the pushed token is absent.

Source files
------------

// File: rtl/pheap_level_link.sv
// Inter-level link for the pipelined heap: skid FIFO carrying {op, key, child position}
// from one level to the next, with an occupancy-aware position hazard lookup.
module pheap_level_link #(
  parameter int unsigned LEVEL = 2,
  parameter int unsigned KW    = 16,
  parameter int unsigned DEPTH = 2
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       flush,
  input  logic                       in_valid,
  output logic                       in_ready,
  input  logic [1:0]                 in_op,
  input  logic [KW-1:0]              in_key,
  input  logic [LEVEL-2:0]           in_pos,
  input  logic                       in_dir,
  output logic                       out_valid,
  input  logic                       out_ready,
  output logic [1:0]                 out_op,
  output logic [KW-1:0]              out_key,
  output logic [LEVEL-1:0]           out_pos,
  output logic [$clog2(DEPTH+1)-1:0] count,
  input  logic [LEVEL-1:0]           chk_pos,
  output logic                       chk_hit,
  output logic                       err
);

  localparam int unsigned PW = $clog2(DEPTH);
  localparam int unsigned CW = $clog2(DEPTH + 1);

  localparam logic [1:0] OpNop      = 2'b00;
  localparam logic [1:0] OpInsert   = 2'b01;
  localparam logic [1:0] OpRemove   = 2'b10;
  localparam logic [1:0] OpReserved = 2'b11;

  logic [1:0]       op_mem  [DEPTH];
  logic [KW-1:0]    key_mem [DEPTH];
  logic [LEVEL-1:0] pos_mem [DEPTH];

  logic [PW-1:0] wr_ptr;
  logic [PW-1:0] rd_ptr;
  logic [CW-1:0] cnt;
  logic          err_flag;

  logic full;
  logic push;
  logic store;
  logic pop;

  always_comb begin
    full      = (cnt == CW'(DEPTH));
    in_ready  = ~full & ~flush;
    out_valid = (cnt != '0);
    push      = in_valid & in_ready;
    // NOP and reserved ops complete the handshake but never occupy an entry.
    store     = push & ((in_op == OpInsert) | (in_op == OpRemove));
    pop       = out_valid & out_ready;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr   <= '0;
      rd_ptr   <= '0;
      cnt      <= '0;
      err_flag <= 1'b0;
      for (int unsigned i = 0; i < DEPTH; i++) begin
        op_mem[i]  <= OpNop;
        key_mem[i] <= '0;
        pos_mem[i] <= '0;
      end
    end else if (flush) begin
      // Storage is left as-is; an empty occupancy window keeps it invisible.
      wr_ptr <= '0;
      rd_ptr <= '0;
      cnt    <= '0;
    end else begin
      if (store) begin
        op_mem[wr_ptr]  <= in_op;
        key_mem[wr_ptr] <= in_key;
        pos_mem[wr_ptr] <= {in_pos, in_dir};
        wr_ptr          <= wr_ptr + PW'(1);
      end
      if (pop) begin
        rd_ptr <= rd_ptr + PW'(1);
      end
      cnt <= cnt + {{(CW-1){1'b0}}, store} - {{(CW-1){1'b0}}, pop};
      if (push && (in_op == OpReserved)) begin
        err_flag <= 1'b1;
      end
    end
  end

  always_comb begin
    out_op  = op_mem[rd_ptr];
    out_key = key_mem[rd_ptr];
    out_pos = pos_mem[rd_ptr];
    count   = cnt;
    err     = err_flag;
  end

  // Only entries inside the occupied window rd_ptr..rd_ptr+cnt-1 may match.
  always_comb begin
    chk_hit = 1'b0;
    for (int unsigned i = 0; i < DEPTH; i++) begin
      if ((CW'(i) < cnt) && (pos_mem[rd_ptr + PW'(i)] == chk_pos)) begin
        chk_hit = 1'b1;
      end
    end
  end

endmodule

// File: tb/tb_pheap_level_link.sv
// Bench for pheap_level_link (LEVEL=3, DEPTH=2): directed vector table, hand sequences for
// fill and streaming, and randomized traffic checked against a queue-based model.
module tb_pheap_level_link;

  localparam int unsigned LEVEL = 3;
  localparam int unsigned KW    = 16;
  localparam int unsigned DEPTH = 2;

  logic             clk = 1'b0;
  logic             rst, flush, in_valid, in_ready, in_dir;
  logic             out_valid, out_ready, chk_hit, err;
  logic [1:0]       in_op, out_op;
  logic [KW-1:0]    in_key, out_key;
  logic [LEVEL-2:0] in_pos;
  logic [LEVEL-1:0] out_pos, chk_pos;
  logic [1:0]       count;

  int checks   = 0;
  int failures = 0;

  always #5 clk = ~clk;

  pheap_level_link #(.LEVEL(LEVEL), .KW(KW), .DEPTH(DEPTH)) dut (
    .clk(clk), .rst(rst), .flush(flush),
    .in_valid(in_valid), .in_ready(in_ready), .in_op(in_op), .in_key(in_key),
    .in_pos(in_pos), .in_dir(in_dir),
    .out_valid(out_valid), .out_ready(out_ready), .out_op(out_op), .out_key(out_key),
    .out_pos(out_pos), .count(count), .chk_pos(chk_pos), .chk_hit(chk_hit), .err(err)
  );

  typedef struct packed {
    logic [LEVEL-1:0] pos;
    logic [1:0]       op;
    logic [KW-1:0]    key;
  } tok_t;

  tok_t          q[$];
  logic [KW-1:0] popped[$];
  bit            m_err;

  typedef struct {
    bit rst, fl, iv; logic [1:0] op; logic [15:0] key; logic [1:0] pos; bit dir, ordy;
    logic [2:0] chk; bit en;
    bit e_ov, e_ir; logic [1:0] e_cnt; bit cpos; logic [2:0] e_pos; bit e_hit, e_err;
  } vec_t;

  task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, got, exp, $time);
    end
  endtask

  task automatic drive(input bit r, input bit f, input bit iv, input logic [1:0] op,
                       input logic [KW-1:0] key, input logic [LEVEL-2:0] pos, input bit dir,
                       input bit ordy, input logic [LEVEL-1:0] chk);
    @(negedge clk);
    rst = r; flush = f; in_valid = iv; in_op = op; in_key = key; in_pos = pos;
    in_dir = dir; out_ready = ordy; chk_pos = chk;
  endtask

  // Compare against the queue model, then advance it to the state after the next edge.
  task automatic mstep(output bit accepted);
    bit exp_ir, hit, do_pop, do_push;
    #1;
    exp_ir = (q.size() < DEPTH) && !flush;
    check("in_ready", in_ready, exp_ir);
    check("out_valid", out_valid, q.size() != 0);
    check("count", count, q.size());
    check("err", err, m_err);
    if (q.size() > 0) begin
      check("out_op", out_op, q[0].op);
      check("out_key", out_key, q[0].key);
      check("out_pos", out_pos, q[0].pos);
    end
    hit = 0;
    foreach (q[i]) if (q[i].pos == chk_pos) hit = 1;
    check("chk_hit", chk_hit, hit);
    accepted = in_valid && exp_ir;
    if (rst) begin
      q.delete();
      m_err = 0;
    end else if (flush) begin
      q.delete();
    end else begin
      do_pop  = (q.size() > 0) && out_ready;
      do_push = in_valid && exp_ir;
      if (do_push && in_op == 2'b11) m_err = 1;
      if (do_pop) begin
        popped.push_back(q[0].key);
        void'(q.pop_front());
      end
      if (do_push && (in_op == 2'b01 || in_op == 2'b10))
        q.push_back('{pos: {in_pos, in_dir}, op: in_op, key: in_key});
    end
  endtask

  vec_t v[20];
  bit   acc;
  int   idx;
  bit   r, f, iv, ordy, dir;
  logic [1:0]       op;
  logic [KW-1:0]    key;
  logic [LEVEL-2:0] pos;
  logic [LEVEL-1:0] chk;
  int unsigned      sel;

  initial begin
    rst = 1'b1; flush = 0; in_valid = 0; in_op = 0; in_key = 0; in_pos = 0; in_dir = 0;
    out_ready = 0; chk_pos = 0;

    // rst fl iv op key pos dir ordy chk | en | ov ir cnt cpos pos hit err
    v[0]  = '{1,0,1,2'd1,16'h1111,2'd3,1,0,3'd0, 0, 0,1,2'd0,0,3'd0,0,0};
    v[1]  = '{1,0,1,2'd1,16'h1111,2'd3,1,0,3'd0, 1, 0,1,2'd0,1,3'd0,0,0};
    v[2]  = '{1,0,1,2'd1,16'h1111,2'd3,1,0,3'd0, 1, 0,1,2'd0,1,3'd0,0,0};
    v[3]  = '{0,0,0,2'd0,16'h0000,2'd0,0,0,3'd0, 1, 0,1,2'd0,1,3'd0,0,0};
    v[4]  = '{0,0,1,2'd1,16'h00A5,2'd2,1,0,3'd5, 1, 0,1,2'd0,1,3'd0,0,0};
    v[5]  = '{0,0,0,2'd0,16'h0000,2'd0,0,0,3'd5, 1, 1,1,2'd1,1,3'd5,1,0};
    v[6]  = '{0,0,0,2'd0,16'h0000,2'd0,0,0,3'd4, 1, 1,1,2'd1,1,3'd5,0,0};
    v[7]  = '{0,0,0,2'd0,16'h0000,2'd0,0,1,3'd5, 1, 1,1,2'd1,1,3'd5,1,0};
    v[8]  = '{0,0,1,2'd0,16'h0000,2'd0,0,0,3'd5, 1, 0,1,2'd0,0,3'd0,0,0};
    v[9]  = '{0,0,1,2'd3,16'h0000,2'd0,0,0,3'd5, 1, 0,1,2'd0,0,3'd0,0,0};
    v[10] = '{0,0,0,2'd0,16'h0000,2'd0,0,0,3'd5, 1, 0,1,2'd0,0,3'd0,0,1};
    v[11] = '{0,0,0,2'd0,16'h0000,2'd0,0,0,3'd5, 1, 0,1,2'd0,0,3'd0,0,1};
    v[12] = '{0,0,1,2'd1,16'h0001,2'd0,0,0,3'd0, 1, 0,1,2'd0,0,3'd0,0,1};
    v[13] = '{0,0,1,2'd2,16'h0002,2'd3,1,0,3'd0, 1, 1,1,2'd1,1,3'd0,1,1};
    v[14] = '{0,1,1,2'd1,16'h0003,2'd1,1,1,3'd7, 1, 1,0,2'd2,1,3'd0,1,1};
    v[15] = '{0,0,0,2'd0,16'h0000,2'd0,0,0,3'd7, 1, 0,1,2'd0,0,3'd0,0,1};
    v[16] = '{0,0,0,2'd0,16'h0000,2'd0,0,0,3'd0, 1, 0,1,2'd0,0,3'd0,0,1};
    v[17] = '{0,0,0,2'd0,16'h0000,2'd0,0,0,3'd3, 1, 0,1,2'd0,0,3'd0,0,1};
    v[18] = '{1,0,0,2'd0,16'h0000,2'd0,0,0,3'd0, 1, 0,1,2'd0,0,3'd0,0,1};
    v[19] = '{0,0,0,2'd0,16'h0000,2'd0,0,0,3'd0, 1, 0,1,2'd0,1,3'd0,0,0};

    for (int i = 0; i < 20; i++) begin
      drive(v[i].rst, v[i].fl, v[i].iv, v[i].op, v[i].key, v[i].pos, v[i].dir, v[i].ordy,
            v[i].chk);
      #1;
      if (v[i].en) begin
        check($sformatf("vec%0d_out_valid", i), out_valid, v[i].e_ov);
        check($sformatf("vec%0d_in_ready", i), in_ready, v[i].e_ir);
        check($sformatf("vec%0d_count", i), count, v[i].e_cnt);
        check($sformatf("vec%0d_chk_hit", i), chk_hit, v[i].e_hit);
        check($sformatf("vec%0d_err", i), err, v[i].e_err);
        if (v[i].cpos) check($sformatf("vec%0d_out_pos", i), out_pos, v[i].e_pos);
      end
    end

    // Table ended right after a reset edge: model starts empty.
    q.delete();
    m_err = 0;

    // Fill and backpressure: third token waits until space frees up.
    popped.delete();
    idx = 0;
    for (int cyc = 0; cyc < 12; cyc++) begin
      drive(0, 0, idx < 3, 2'd1, KW'(idx + 1), (LEVEL-1)'(idx), 0, cyc >= 4, 3'd0);
      mstep(acc);
      if (cyc == 2) check("fill_in_ready_full", in_ready, 0);
      if (cyc == 3) check("fill_count_full", count, 2);
      if (acc && idx < 3) idx++;
    end
    check("fill_pop_count", popped.size(), 3);
    for (int i = 0; i < 3; i++)
      check("fill_order", popped.size() > i ? popped[i] : 16'hFFFF, i + 1);

    // Steady stream: one token per cycle, occupancy pinned at one.
    popped.delete();
    idx = 0;
    for (int cyc = 0; cyc < 22; cyc++) begin
      drive(0, 0, idx < 20, 2'd2, KW'(100 + idx), (LEVEL-1)'(idx), idx[0], 1, 3'd0);
      mstep(acc);
      if (cyc >= 1 && cyc <= 19) check("stream_count", count, 1);
      if (acc && idx < 20) idx++;
    end
    check("stream_pop_count", popped.size(), 20);
    for (int i = 0; i < 20; i++)
      check("stream_order", popped.size() > i ? popped[i] : 16'hFFFF, 100 + i);

    // Randomized traffic against the queue model.
    for (int n = 0; n < 600; n++) begin
      r    = ($urandom_range(0, 99) == 0);
      f    = ($urandom_range(0, 24) == 0);
      iv   = ($urandom_range(0, 3) != 0);
      ordy = ($urandom_range(0, 2) != 0);
      sel  = $urandom_range(0, 9);
      op   = (sel < 4) ? 2'd1 : (sel < 8) ? 2'd2 : (sel == 8) ? 2'd0 : 2'd3;
      key  = KW'($urandom);
      pos  = (LEVEL-1)'($urandom);
      dir  = 1'($urandom);
      chk  = LEVEL'($urandom);
      drive(r, f, iv, op, key, pos, dir, ordy, chk);
      mstep(acc);
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
